// File: rtl/systolic_matmul.sv
// Output-stationary DIM x DIM systolic matrix multiplier, C = A * B.
// Operands stream in one (column of A, row of B) pair per accepted step.
// The array skews them internally, flushes with zeros, and then hands C
// out one row at a time over a valid/ready port.
module systolic_matmul #(
  parameter int BITS     = 8,
  parameter int DIM      = 8,
  parameter int ACC_BITS = 24,
  parameter int KW       = 16,
  parameter int SAT      = 0
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic                                    start,
  input  logic [KW-1:0]                           k_len,
  input  logic                                    accumulate,
  output logic                                    busy,
  input  logic                                    in_valid,
  output logic                                    in_ready,
  input  logic [DIM*BITS-1:0]                     a_in,
  input  logic [DIM*BITS-1:0]                     b_in,
  output logic                                    out_valid,
  input  logic                                    out_ready,
  output logic [((DIM > 1) ? $clog2(DIM) : 1)-1:0] out_row,
  output logic [DIM*ACC_BITS-1:0]                 out_data,
  output logic                                    done
);

  localparam int RW      = (DIM > 1) ? $clog2(DIM) : 1;
  localparam int FW      = $clog2(2 * DIM);
  localparam int FLUSH_N = (DIM > 1) ? 2 * DIM - 3 : 0;

  typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DRAIN} state_t;

  state_t        state;
  logic [KW-1:0] k_left;
  logic [FW-1:0] f_left;
  logic          step;
  logic          job_start;
  logic          clr_acc;

  logic signed [BITS-1:0]     a_w   [DIM][DIM];
  logic signed [BITS-1:0]     b_w   [DIM][DIM];
  logic signed [ACC_BITS-1:0] acc_w [DIM][DIM];

  // Clamp a one-bit-wider sum back into the accumulator range (or wrap).
  function automatic logic signed [ACC_BITS-1:0] clamp_acc(input logic signed [ACC_BITS:0] s);
    if ((SAT != 0) && (s[ACC_BITS] != s[ACC_BITS-1]))
      return s[ACC_BITS] ? {1'b1, {(ACC_BITS-1){1'b0}}} : {1'b0, {(ACC_BITS-1){1'b1}}};
    return s[ACC_BITS-1:0];
  endfunction

  // Signed multiply-accumulate; product is full width, sign-extended.
  function automatic logic signed [ACC_BITS-1:0] mac(input logic signed [ACC_BITS-1:0] acc,
                                                     input logic signed [BITS-1:0]     a,
                                                     input logic signed [BITS-1:0]     b);
    logic signed [2*BITS-1:0] prod;
    logic signed [ACC_BITS:0] sum;
    prod = (2*BITS)'(a) * (2*BITS)'(b);
    sum  = (ACC_BITS+1)'(acc) + (ACC_BITS+1)'(prod);
    return clamp_acc(sum);
  endfunction

  assign job_start = (state == IDLE) && start;
  assign clr_acc   = job_start && !accumulate;
  assign step      = ((state == LOAD) && in_valid) || (state == FLUSH);
  assign busy      = (state != IDLE);
  assign in_ready  = (state == LOAD);
  assign out_valid = (state == DRAIN);

  // Job sequencing: count operand steps, flush cycles and drained rows.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      k_left  <= '0;
      f_left  <= '0;
      out_row <= '0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          k_left  <= k_len;
          out_row <= '0;
          state   <= (k_len != '0) ? LOAD : DRAIN;
        end
        LOAD: if (in_valid) begin
          k_left <= k_left - 1'b1;
          if (k_left == KW'(1)) begin
            if (DIM == 1) state <= DRAIN;
            else begin
              state  <= FLUSH;
              f_left <= FW'(FLUSH_N);
            end
          end
        end
        FLUSH: if (f_left == '0) state <= DRAIN;
               else              f_left <= f_left - 1'b1;
        DRAIN: if (out_ready) begin
          if (out_row == RW'(DIM - 1)) begin
            state   <= IDLE;
            out_row <= '0;
            done    <= 1'b1;
          end else begin
            out_row <= out_row + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // ---- stage p0: input skew, row i of A / column i of B delayed by i steps ----
  for (genvar i = 0; i < DIM; i++) begin : g_skew
    logic signed [BITS-1:0] a_src_p0;
    logic signed [BITS-1:0] b_src_p0;
    assign a_src_p0 = (state == FLUSH) ? '0 : $signed(a_in[i*BITS +: BITS]);
    assign b_src_p0 = (state == FLUSH) ? '0 : $signed(b_in[i*BITS +: BITS]);
    if (i == 0) begin : g_direct
      assign a_w[0][0] = a_src_p0;
      assign b_w[0][0] = b_src_p0;
    end else begin : g_sr
      logic signed [BITS-1:0] a_sr_p0 [i];
      logic signed [BITS-1:0] b_sr_p0 [i];
      // Shift registers advance on steps and are emptied at every job start.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int d = 0; d < i; d++) begin
            a_sr_p0[d] <= '0;
            b_sr_p0[d] <= '0;
          end
        end else if (job_start) begin
          for (int d = 0; d < i; d++) begin
            a_sr_p0[d] <= '0;
            b_sr_p0[d] <= '0;
          end
        end else if (step) begin
          a_sr_p0[0] <= a_src_p0;
          b_sr_p0[0] <= b_src_p0;
          for (int d = 1; d < i; d++) begin
            a_sr_p0[d] <= a_sr_p0[d-1];
            b_sr_p0[d] <= b_sr_p0[d-1];
          end
        end
      end
      assign a_w[i][0] = a_sr_p0[i-1];
      assign b_w[0][i] = b_sr_p0[i-1];
    end
  end

  // ---- stage p1: PE grid, a moves east, b moves south, C stays put ----
  for (genvar i = 0; i < DIM; i++) begin : g_row
    for (genvar j = 0; j < DIM; j++) begin : g_col
      logic signed [ACC_BITS-1:0] acc_p1;
      // Accumulator: cleared by a non-accumulating start, updated on steps.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       acc_p1 <= '0;
        else if (clr_acc) acc_p1 <= '0;
        else if (step)    acc_p1 <= mac(acc_p1, a_w[i][j], b_w[i][j]);
      end
      assign acc_w[i][j] = acc_p1;

      if (j < DIM - 1) begin : g_a_fwd
        logic signed [BITS-1:0] a_p1;
        // Forward a to the eastern neighbour one step later.
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n)         a_p1 <= '0;
          else if (job_start) a_p1 <= '0;
          else if (step)      a_p1 <= a_w[i][j];
        end
        assign a_w[i][j+1] = a_p1;
      end

      if (i < DIM - 1) begin : g_b_fwd
        logic signed [BITS-1:0] b_p1;
        // Forward b to the southern neighbour one step later.
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n)         b_p1 <= '0;
          else if (job_start) b_p1 <= '0;
          else if (step)      b_p1 <= b_w[i][j];
        end
        assign b_w[i+1][j] = b_p1;
      end
    end
  end

  // ---- stage p2: result row select; array is frozen while draining ----
  always_comb begin
    out_data = '0;
    for (int j = 0; j < DIM; j++)
      out_data[j*ACC_BITS +: ACC_BITS] = acc_w[out_row][j];
  end

endmodule

// File: tb/tb_systolic_matmul.sv
// Directed bench for systolic_matmul: DIM=4 main instance plus a pair of
// 16-bit accumulator instances (saturating and wrapping) sharing stimulus.
module tb_systolic_matmul;
  localparam int BITS = 8;
  localparam int DIM  = 4;
  localparam int ACC  = 24;
  localparam int KW   = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic                rst_n, start, accumulate, in_valid, out_ready;
  logic [KW-1:0]       k_len;
  logic                busy, in_ready, out_valid, done;
  logic [DIM*BITS-1:0] a_in, b_in;
  logic [1:0]          out_row;
  logic [DIM*ACC-1:0]  out_data;

  logic                s_start, s_acc, s_in_valid, s_out_ready;
  logic [KW-1:0]       s_k_len;
  logic [DIM*BITS-1:0] s_a, s_b;
  logic                s1_busy, s1_in_ready, s1_out_valid, s1_done;
  logic                s0_busy, s0_in_ready, s0_out_valid, s0_done;
  logic [1:0]          s1_row, s0_row;
  logic [DIM*16-1:0]   s1_data, s0_data;

  systolic_matmul #(.BITS(BITS), .DIM(DIM), .ACC_BITS(ACC), .KW(KW), .SAT(0)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .k_len(k_len), .accumulate(accumulate),
    .busy(busy), .in_valid(in_valid), .in_ready(in_ready), .a_in(a_in), .b_in(b_in),
    .out_valid(out_valid), .out_ready(out_ready), .out_row(out_row),
    .out_data(out_data), .done(done));

  systolic_matmul #(.BITS(BITS), .DIM(DIM), .ACC_BITS(16), .KW(KW), .SAT(1)) dut_sat (
    .clk(clk), .rst_n(rst_n), .start(s_start), .k_len(s_k_len), .accumulate(s_acc),
    .busy(s1_busy), .in_valid(s_in_valid), .in_ready(s1_in_ready), .a_in(s_a), .b_in(s_b),
    .out_valid(s1_out_valid), .out_ready(s_out_ready), .out_row(s1_row),
    .out_data(s1_data), .done(s1_done));

  systolic_matmul #(.BITS(BITS), .DIM(DIM), .ACC_BITS(16), .KW(KW), .SAT(0)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .start(s_start), .k_len(s_k_len), .accumulate(s_acc),
    .busy(s0_busy), .in_valid(s_in_valid), .in_ready(s0_in_ready), .a_in(s_a), .b_in(s_b),
    .out_valid(s0_out_valid), .out_ready(s_out_ready), .out_row(s0_row),
    .out_data(s0_data), .done(s0_done));

  int checks   = 0;
  int failures = 0;
  int t_load   = 0;
  int t_done   = 0;

  int A [DIM][16];
  int B [16][DIM];
  int C [DIM][DIM];

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] row_vec(input int r);
    logic [127:0] v;
    int t;
    v = '0;
    for (int j = 0; j < DIM; j++) begin
      t = C[r][j];
      v[j*ACC +: ACC] = t[ACC-1:0];
    end
    return v;
  endfunction

  // Called at a negedge with the DUT idle; returns at the first LOAD/DRAIN negedge.
  task automatic do_start(input int k, input bit acc);
    start      = 1'b1;
    k_len      = k[KW-1:0];
    accumulate = acc;
    @(negedge clk);
    start  = 1'b0;
    t_load = cyc;
    if (!acc)
      for (int i = 0; i < DIM; i++)
        for (int j = 0; j < DIM; j++) C[i][j] = 0;
  endtask

  task automatic feed(input int k0, input int k, input int vpct);
    for (int s = 0; s < k; s++) begin
      bit got = 1'b0;
      int n = 0;
      while (!got && n < 200) begin
        int t;
        in_valid = ($urandom_range(99) < vpct);
        for (int i = 0; i < DIM; i++) begin
          t = A[i][k0+s];
          a_in[i*BITS +: BITS] = t[BITS-1:0];
          t = B[k0+s][i];
          b_in[i*BITS +: BITS] = t[BITS-1:0];
        end
        if (s == 0 && n == 0) chk("load_in_ready", in_ready, 1);
        got = in_valid && in_ready;
        @(negedge clk);
        n++;
      end
      if (!got) chk("feed_timeout", 0, 1);
      for (int i = 0; i < DIM; i++)
        for (int j = 0; j < DIM; j++) C[i][j] += A[i][k0+s] * B[k0+s][j];
    end
    in_valid = 1'b0;
  endtask

  // Returns at the negedge of the first IDLE cycle (done should be high).
  task automatic drain(input int rpct, input string tag);
    int row = 0;
    int n = 0;
    bit stalled = 1'b0;
    logic [DIM*ACC-1:0] held = '0;
    while (row < DIM && n < 300) begin
      if (stalled) chk($sformatf("%s_hold", tag), out_data, held);
      stalled   = 1'b0;
      out_ready = ($urandom_range(99) < rpct);
      if (out_valid) begin
        if (out_ready) begin
          chk($sformatf("%s_row%0d_idx", tag, row), out_row, row);
          chk($sformatf("%s_row%0d_data", tag, row), out_data, row_vec(row));
          row++;
        end else begin
          held    = out_data;
          stalled = 1'b1;
        end
      end
      @(negedge clk);
      n++;
    end
    if (row < DIM) chk($sformatf("%s_drain_timeout", tag), row, DIM);
    chk($sformatf("%s_done", tag), {done, busy, out_valid}, 3'b100);
    t_done = cyc;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; accumulate = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    k_len = '0; a_in = '0; b_in = '0;
    s_start = 1'b0; s_acc = 1'b0; s_in_valid = 1'b0; s_out_ready = 1'b1;
    s_k_len = '0; s_a = '0; s_b = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_row", out_row, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_done", done, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Identity A, B[k][j] = 4k+j+1, full throughput, latency check.
    for (int i = 0; i < DIM; i++)
      for (int k = 0; k < 4; k++) begin
        A[i][k] = (i == k) ? 1 : 0;
        B[k][i] = 4 * k + i + 1;
      end
    out_ready = 1'b1;
    do_start(4, 1'b0);
    feed(0, 4, 100);
    drain(100, "ident");
    chk("ident_latency", t_done - t_load, 14);
    @(negedge clk);
    chk("ident_done_pulse", {done, busy}, 2'b00);

    // Random signed operands with in_valid and out_ready throttled.
    for (int i = 0; i < DIM; i++)
      for (int k = 0; k < 3; k++) begin
        A[i][k] = int'($urandom_range(255)) - 128;
        B[k][i] = int'($urandom_range(255)) - 128;
      end
    A[0][0] = -128; B[0][0] = -128; A[3][2] = 127; B[2][3] = -128;
    do_start(3, 1'b0);
    feed(0, 3, 50);
    drain(30, "rand");

    // K tiling: two K=2 jobs, second accumulating; start taken on the done cycle.
    for (int i = 0; i < DIM; i++)
      for (int k = 0; k < 4; k++) begin
        A[i][k] = int'($urandom_range(255)) - 128;
        B[k][i] = int'($urandom_range(255)) - 128;
      end
    do_start(2, 1'b0);
    feed(0, 2, 100);
    drain(100, "tile1");
    do_start(2, 1'b1);
    feed(2, 2, 100);
    drain(100, "tile2");

    // k_len = 0 goes straight to DRAIN; in_valid held high must not step the array.
    @(negedge clk);
    a_in = {DIM{8'h35}}; b_in = {DIM{8'hC3}};
    do_start(0, 1'b0);
    in_valid = 1'b1;
    chk("k0_in_ready", {in_ready, out_valid}, 2'b01);
    drain(100, "k0");
    in_valid = 1'b0;

    // Reset asserted during FLUSH aborts the job and clears C.
    for (int i = 0; i < DIM; i++)
      for (int k = 0; k < 2; k++) begin
        A[i][k] = 50 + i;
        B[k][i] = 60 + k;
      end
    do_start(2, 1'b0);
    feed(0, 2, 100);
    chk("flush_state", {busy, in_ready, out_valid}, 3'b100);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_in_ready", in_ready, 0);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_out_row", out_row, 0);
    chk("abort_out_data", out_data, 0);
    chk("abort_done", done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < DIM; i++)
      for (int j = 0; j < DIM; j++) begin
        C[i][j] = 0;
        A[i][j] = 1;
        B[i][j] = 1;
      end
    do_start(1, 1'b1);
    feed(0, 1, 100);
    drain(100, "post_rst");

    // Saturating vs wrapping 16-bit accumulators, all operands -128, K=4.
    s_a = {DIM{8'h80}}; s_b = {DIM{8'h80}};
    s_k_len = 16'd4; s_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0; s_in_valid = 1'b1;
    repeat (4) @(negedge clk);
    s_in_valid = 1'b0;
    begin
      int rows = 0;
      for (int n = 0; n < 40 && rows < DIM; n++) begin
        if (s1_out_valid) begin
          chk($sformatf("sat_row%0d", rows), s1_data, {DIM{16'h7FFF}});
          chk($sformatf("wrap_row%0d", rows), s0_data, 0);
          rows++;
        end
        @(negedge clk);
      end
      chk("sat_rows", rows, DIM);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
